// File: rtl/iob_pll_drp_reconfig_if.sv
`default_nettype none
// ============================================================================
// iob_pll_drp_reconfig_if : divide request, PLL DRP port and PLL RST/LOCKED
// Revision: 1.0
// ============================================================================
interface iob_pll_drp_reconfig_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [7:0]  req_div_i;
  logic [6:0]  daddr_o;
  logic [15:0] di_o;
  logic        den_o;
  logic        dwe_o;
  logic [15:0] do_i;
  logic        drdy_i;
  logic        pll_rst_o;
  logic        locked_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  cur_div_o;

  modport slave (
    input  req_valid_i, req_div_i, do_i, drdy_i, locked_i,
    output req_ready_o, daddr_o, di_o, den_o, dwe_o, pll_rst_o,
           busy_o, done_o, err_o, cur_div_o
  );

  modport master (
    output req_valid_i, req_div_i, do_i, drdy_i, locked_i,
    input  req_ready_o, daddr_o, di_o, den_o, dwe_o, pll_rst_o,
           busy_o, done_o, err_o, cur_div_o
  );
endinterface
`default_nettype wire

// File: rtl/iob_pll_drp_reconfig.sv
`default_nettype none
// ============================================================================
// iob_pll_drp_reconfig : runtime CLKOUT0 divider reprogramming over PLL DRP
// Revision: 1.0
// ============================================================================
module iob_pll_drp_reconfig #(
  parameter int unsigned DEFAULT_DIV  = 10,
  parameter int unsigned RST_HOLD     = 16,
  parameter int unsigned DRP_TIMEOUT  = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  iob_pll_drp_reconfig_if.slave   bus
);

  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] C_DRP_LAST  = CNT_W'(DRP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [6:0]       C_REG1      = 7'h08;
  localparam logic [6:0]       C_REG2      = 7'h09;
  localparam logic [7:0]       C_DEF_DIV   = 8'(DEFAULT_DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_RD, S_RD_W, S_WR, S_WR_W, S_LOCK, S_OK, S_FAIL
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_div;
  logic [7:0]       r_cur_div;
  logic [6:0]       r_daddr;
  logic [15:0]      r_di;
  logic             r_den, r_dwe, r_pll_rst;
  logic             r_ready, r_busy, r_done, r_err;
  logic             r_lock_meta, r_lock_sync;

  logic [5:0]       w_high, w_low;
  logic             w_edge, w_nocount, w_legal;
  logic [15:0]      w_reg1, w_reg2;

  // Divide 1 is the bypass encoding; otherwise split into high/low counts.
  always_comb begin
    w_high    = r_div[6:1];
    w_low     = 6'(r_div - {2'b00, r_div[6:1]});
    w_edge    = r_div[0];
    w_nocount = 1'b0;
    if (r_div == 8'd1) begin
      w_high    = 6'd1;
      w_low     = 6'd1;
      w_edge    = 1'b0;
      w_nocount = 1'b1;
    end
  end

  assign w_reg1  = (bus.do_i & 16'hF000) | {4'h0, w_high, w_low};
  assign w_reg2  = (bus.do_i & 16'hFF3F) | {8'h00, w_edge, w_nocount, 6'h00};
  assign w_legal = (bus.req_div_i != 8'd0) && (bus.req_div_i <= 8'd126);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= bus.locked_i;
      r_lock_sync <= r_lock_meta;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_cur_div <= C_DEF_DIV;
      r_daddr   <= '0;
      r_di      <= '0;
      r_den     <= 1'b0;
      r_dwe     <= 1'b0;
      r_pll_rst <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_den  <= 1'b0;
      r_dwe  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.req_valid_i) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= bus.req_div_i;
            if (!w_legal) begin
              r_state <= S_FAIL;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state   <= S_RST;
              r_pll_rst <= 1'b1;
            end
          end
        end
        S_RST: begin
          if (r_cnt == C_RST_LAST) begin
            r_state <= S_RD;
            r_cnt   <= '0;
            r_den   <= 1'b1;
            r_daddr <= C_REG1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_RD: begin
          r_state <= S_RD_W;
          r_cnt   <= '0;
        end
        S_RD_W: begin
          if (bus.drdy_i) begin
            r_state <= S_WR;
            r_cnt   <= '0;
            r_den   <= 1'b1;
            r_dwe   <= 1'b1;
            r_di    <= (r_daddr == C_REG1) ? w_reg1 : w_reg2;
          end else if (r_cnt == C_DRP_LAST) begin
            r_state   <= S_FAIL;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_WR: begin
          r_state <= S_WR_W;
          r_cnt   <= '0;
        end
        S_WR_W: begin
          if (bus.drdy_i) begin
            r_cnt <= '0;
            if (r_daddr == C_REG1) begin
              r_state <= S_RD;
              r_den   <= 1'b1;
              r_daddr <= C_REG2;
            end else begin
              r_state   <= S_LOCK;
              r_pll_rst <= 1'b0;
            end
          end else if (r_cnt == C_DRP_LAST) begin
            r_state   <= S_FAIL;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_LOCK: begin
          if (r_lock_sync) begin
            r_state   <= S_OK;
            r_cnt     <= '0;
            r_done    <= 1'b1;
            r_cur_div <= r_div;
          end else if (r_cnt == C_LOCK_LAST) begin
            r_state <= S_FAIL;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_OK, S_FAIL: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_pll_rst <= 1'b0;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;
  assign bus.daddr_o     = r_daddr;
  assign bus.di_o        = r_di;
  assign bus.den_o       = r_den;
  assign bus.dwe_o       = r_dwe;
  assign bus.pll_rst_o   = r_pll_rst;
  assign bus.cur_div_o   = r_cur_div;

endmodule
`default_nettype wire

// File: tb/tb_iob_pll_drp_reconfig.sv
`default_nettype none
// ============================================================================
// tb_iob_pll_drp_reconfig : bench with DRP/PLL behavioural models
// Revision: 1.0
// ============================================================================
module tb_iob_pll_drp_reconfig;
  localparam int DEFAULT_DIV  = 10;
  localparam int RST_HOLD     = 16;
  localparam int DRP_TIMEOUT  = 64;
  localparam int LOCK_TIMEOUT = 300;

  typedef struct packed {
    logic        we;
    logic [6:0]  a;
    logic [15:0] d;
  } acc_t;

  logic clk_i    = 1'b0;
  logic arst_n_i = 1'b0;
  iob_pll_drp_reconfig_if bus();

  iob_pll_drp_reconfig #(
    .DEFAULT_DIV (DEFAULT_DIV),
    .RST_HOLD    (RST_HOLD),
    .DRP_TIMEOUT (DRP_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [15:0] mem [0:127];
  acc_t acc_q[$];
  int lat_fixed = 0, stall_addr = -1, proto_err = 0;
  int t_rst_rise = 0, t_rst_fall = 0, t_first_den = 0, t_last_den = 0;
  int t_lock_rise = 0, t_done = 0, n_rst_rise = 0;
  bit lock_hold_low = 0;
  int lock_delay = 20;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // DRP slave: optional per-access latency, optional stall on one address
  initial begin : drp_model
    bit pend, prev_rst, seen_den;
    int wl;
    logic [15:0] pend_d;
    acc_t e;
    pend = 0; prev_rst = 0; seen_den = 0; wl = 0; pend_d = '0;
    bus.drdy_i = 1'b0;
    bus.do_i   = '0;
    forever begin
      @(negedge clk_i);
      if (!arst_n_i) begin
        pend = 0; prev_rst = 0;
        bus.drdy_i = 1'b0;
      end else begin
        bus.drdy_i = 1'b0;
        if (pend) begin
          if (wl == 0) begin bus.drdy_i = 1'b1; bus.do_i = pend_d; pend = 0; end
          else wl--;
        end
        if (bus.pll_rst_o && !prev_rst) begin t_rst_rise = cyc; seen_den = 0; n_rst_rise++; end
        if (!bus.pll_rst_o && prev_rst) t_rst_fall = cyc;
        prev_rst = bus.pll_rst_o;
        if (bus.den_o) begin
          if (!seen_den) begin seen_den = 1; t_first_den = cyc; end
          t_last_den = cyc;
          if (pend) proto_err++;
          e.we = bus.dwe_o; e.a = bus.daddr_o; e.d = bus.di_o;
          acc_q.push_back(e);
          if (bus.dwe_o) mem[bus.daddr_o] = bus.di_o;
          pend_d = mem[bus.daddr_o];
          if (!bus.dwe_o && int'(bus.daddr_o) == stall_addr) pend = 0;
          else begin
            pend = 1;
            wl = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
          end
        end
      end
    end
  end

  initial begin : pll_model
    int lk;
    lk = 0;
    bus.locked_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!arst_n_i || bus.pll_rst_o) begin
        bus.locked_i = 1'b0; lk = 0;
      end else if (!lock_hold_low && !bus.locked_i) begin
        lk++;
        if (lk >= lock_delay) begin bus.locked_i = 1'b1; t_lock_rise = cyc; end
      end
    end
  end

  // Reference register images from the divider encoding rules
  function automatic logic [15:0] exp_reg1(int div, logic [15:0] rd);
    int h, l;
    h = (div == 1) ? 1 : div / 2;
    l = (div == 1) ? 1 : div - h;
    return (rd & 16'hF000) | 16'(h * 64) | 16'(l);
  endfunction

  function automatic logic [15:0] exp_reg2(int div, logic [15:0] rd);
    int ed, nc;
    ed = (div == 1) ? 0 : div % 2;
    nc = (div == 1) ? 1 : 0;
    return (rd & 16'hFF3F) | 16'(ed * 128) | 16'(nc * 64);
  endfunction

  task automatic send_req(input logic [7:0] div);
    @(negedge clk_i); #1;
    bus.req_valid_i = 1'b1;
    bus.req_div_i   = div;
    @(negedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    bus.req_div_i   = 8'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit got, output bit err);
    got = 0; err = 0;
    for (int i = 0; i < budget && !got; i++) begin
      if (bus.done_o === 1'b1) begin got = 1; err = bus.err_o; t_done = cyc; end
      else begin @(negedge clk_i); #1; end
    end
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    arst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    flags = {bus.req_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.den_o, bus.dwe_o, bus.pll_rst_o};
    n_tests++;
    if (flags !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b", flags, 7'b1000000);
    end
    n_tests++;
    if (bus.cur_div_o !== 8'(DEFAULT_DIV) || bus.daddr_o !== 7'd0 || bus.di_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: cur_div %0d daddr %h di %h expected %0d 0 0",
               bus.cur_div_o, bus.daddr_o, bus.di_o, DEFAULT_DIV);
    end
    arst_n_i = 1'b1;
    repeat (lock_delay + 5) @(negedge clk_i);
    #1;
  endtask

  task automatic test_directed();
    int          tdiv [3] = '{10, 7, 1};
    logic [15:0] tm8  [3] = '{16'hA000, 16'h0000, 16'hFFFF};
    logic [15:0] tm9  [3] = '{16'h1C00, 16'h00C0, 16'hFFFF};
    logic [15:0] te8  [3] = '{16'hA145, 16'h00C4, 16'hF041};
    logic [15:0] te9  [3] = '{16'h1C00, 16'h0080, 16'hFF7F};
    bit got, err, bad;
    for (int i = 0; i < 3; i++) begin
      mem[8] = tm8[i]; mem[9] = tm9[i];
      acc_q.delete(); lat_fixed = 0;
      send_req(8'(tdiv[i]));
      wait_done(2000, got, err);
      n_tests++;
      if ({got, err} !== 2'b10) begin
        n_fail++; $display("FAIL dir_done div=%0d: got done=%b err=%b expected 1 0", tdiv[i], got, err);
      end
      n_tests++;
      if (bus.cur_div_o !== 8'(tdiv[i])) begin
        n_fail++; $display("FAIL dir_cur_div: got %0d expected %0d", bus.cur_div_o, tdiv[i]);
      end
      bad = (acc_q.size() != 4);
      if (!bad) bad = acc_q[0].we !== 1'b0 || acc_q[0].a !== 7'h08 ||
                      acc_q[1].we !== 1'b1 || acc_q[1].a !== 7'h08 || acc_q[1].d !== te8[i] ||
                      acc_q[2].we !== 1'b0 || acc_q[2].a !== 7'h09 ||
                      acc_q[3].we !== 1'b1 || acc_q[3].a !== 7'h09 || acc_q[3].d !== te9[i];
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL dir_drp div=%0d: got %0d accesses, w08=%h w09=%h expected 4, %h %h",
                 tdiv[i], acc_q.size(), mem[8], mem[9], te8[i], te9[i]);
      end
      n_tests++;
      if (t_first_den - t_rst_rise < RST_HOLD) begin
        n_fail++; $display("FAIL dir_rst_hold: got %0d cycles expected >= %0d", t_first_den - t_rst_rise, RST_HOLD);
      end
      @(negedge clk_i); #1;
      n_tests++;
      if (bus.done_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL dir_pulse: got done=%b ready=%b expected 0 1", bus.done_o, bus.req_ready_o);
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] tdiv [3] = '{8'd0, 8'd127, 8'd0};
    logic [7:0] prev;
    int rises;
    bit got, err;
    tdiv[2] = 8'($urandom_range(128, 255));
    for (int i = 0; i < 3; i++) begin
      prev = bus.cur_div_o; rises = n_rst_rise; acc_q.delete();
      send_req(tdiv[i]);
      wait_done(50, got, err);
      n_tests++;
      if ({got, err} !== 2'b11) begin
        n_fail++; $display("FAIL ill_err div=%0d: got done=%b err=%b expected 1 1", tdiv[i], got, err);
      end
      n_tests++;
      if (acc_q.size() != 0 || n_rst_rise != rises || bus.cur_div_o !== prev) begin
        n_fail++;
        $display("FAIL ill_side div=%0d: got den=%0d rst_rises=%0d cur=%0d expected 0 0 %0d",
                 tdiv[i], acc_q.size(), n_rst_rise - rises, bus.cur_div_o, prev);
      end
    end
  endtask

  task automatic test_random();
    int div;
    logic [15:0] m8, m9, e8, e9;
    bit got, err, bad;
    lat_fixed = -1;
    for (int i = 0; i < 16; i++) begin
      div = int'($urandom_range(1, 126));
      m8 = 16'($urandom); m9 = 16'($urandom);
      mem[8] = m8; mem[9] = m9;
      e8 = exp_reg1(div, m8); e9 = exp_reg2(div, m9);
      lock_delay = int'($urandom_range(5, 40));
      acc_q.delete();
      send_req(8'(div));
      wait_done(2000, got, err);
      bad = ({got, err} !== 2'b10) || bus.cur_div_o !== 8'(div) || acc_q.size() != 4;
      if (!bad) bad = acc_q[0].we || acc_q[0].a !== 7'h08 || !acc_q[1].we || acc_q[1].d !== e8 ||
                      acc_q[2].we || acc_q[2].a !== 7'h09 || !acc_q[3].we || acc_q[3].a !== 7'h09 ||
                      acc_q[3].d !== e9;
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand div=%0d: got done=%b err=%b cur=%0d n=%0d w08=%h w09=%h expected 1 0 %0d 4 %h %h",
                 div, got, err, bus.cur_div_o, acc_q.size(), mem[8], mem[9], div, e8, e9);
      end
    end
    lat_fixed = 0; lock_delay = 20;
  endtask

  task automatic test_back_to_back();
    bit got, err, leak;
    logic [7:0] div;
    div = 8'($urandom_range(2, 126));
    leak = 0; got = 0; err = 0;
    send_req(div);
    bus.req_valid_i = 1'b1; bus.req_div_i = 8'd0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (bus.done_o === 1'b1) begin got = 1; err = bus.err_o; end
      else begin
        if (bus.req_ready_o !== 1'b0 || bus.busy_o !== 1'b1) leak = 1;
        @(negedge clk_i); #1;
      end
    end
    bus.req_valid_i = 1'b0;
    n_tests++;
    if (leak) begin
      n_fail++; $display("FAIL b2b_ready: got ready high while busy expected low");
    end
    n_tests++;
    if ({got, err} !== 2'b10 || bus.cur_div_o !== div) begin
      n_fail++; $display("FAIL b2b_done: got done=%b err=%b cur=%0d expected 1 0 %0d", got, err, bus.cur_div_o, div);
    end
    div = 8'($urandom_range(2, 126));
    send_req(div);
    wait_done(2000, got, err);
    n_tests++;
    if ({got, err} !== 2'b10 || bus.cur_div_o !== div) begin
      n_fail++; $display("FAIL b2b_next: got done=%b err=%b cur=%0d expected 1 0 %0d", got, err, bus.cur_div_o, div);
    end
  endtask

  task automatic test_drp_timeout();
    bit got, err;
    logic [7:0] prev;
    prev = bus.cur_div_o; stall_addr = 9; acc_q.delete();
    send_req(8'd33);
    wait_done(2000, got, err);
    n_tests++;
    if ({got, err} !== 2'b11 || t_done - t_last_den != DRP_TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL drp_timeout: got done=%b err=%b after %0d cycles expected 1 1 after %0d",
               got, err, t_done - t_last_den, DRP_TIMEOUT + 1);
    end
    n_tests++;
    if (bus.pll_rst_o !== 1'b0 || bus.cur_div_o !== prev || acc_q.size() != 3) begin
      n_fail++;
      $display("FAIL drp_timeout_side: got rst=%b cur=%0d n=%0d expected 0 %0d 3",
               bus.pll_rst_o, bus.cur_div_o, acc_q.size(), prev);
    end
    stall_addr = -1;
  endtask

  task automatic test_lock();
    bit got, err;
    logic [7:0] prev;
    prev = bus.cur_div_o; lock_hold_low = 1;
    send_req(8'd45);
    wait_done(LOCK_TIMEOUT + 500, got, err);
    n_tests++;
    if ({got, err} !== 2'b11 || t_done - t_rst_fall != LOCK_TIMEOUT || bus.cur_div_o !== prev) begin
      n_fail++;
      $display("FAIL lock_timeout: got done=%b err=%b after %0d cur=%0d expected 1 1 after %0d cur %0d",
               got, err, t_done - t_rst_fall, bus.cur_div_o, LOCK_TIMEOUT, prev);
    end
    lock_hold_low = 0; lock_delay = 100;
    send_req(8'd46);
    wait_done(2000, got, err);
    n_tests++;
    if ({got, err} !== 2'b10 || t_done - t_lock_rise != 3 || bus.cur_div_o !== 8'd46) begin
      n_fail++;
      $display("FAIL lock_late: got done=%b err=%b lag=%0d cur=%0d expected 1 0 3 46",
               got, err, t_done - t_lock_rise, bus.cur_div_o);
    end
    lock_delay = 20;
  endtask

  task automatic test_async_reset();
    bit got, err, seen;
    logic [6:0] flags;
    lat_fixed = 4; seen = 0;
    send_req(8'd77);
    for (int i = 0; i < 500 && !seen; i++) begin
      if (bus.den_o === 1'b1 && bus.dwe_o === 1'b1) seen = 1;
      else begin @(negedge clk_i); #1; end
    end
    @(negedge clk_i); #1;
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL arst_setup: got no DRP write expected one");
    end
    arst_n_i = 1'b0;
    #1;
    flags = {bus.req_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.den_o, bus.dwe_o, bus.pll_rst_o};
    n_tests++;
    if (flags !== 7'b1000000 || bus.cur_div_o !== 8'(DEFAULT_DIV)) begin
      n_fail++;
      $display("FAIL arst_values: got flags %b cur %0d expected %b %0d", flags, bus.cur_div_o, 7'b1000000, DEFAULT_DIV);
    end
    repeat (3) @(negedge clk_i);
    #2 arst_n_i = 1'b1;
    lat_fixed = 0;
    repeat (30) @(negedge clk_i);
    #1;
    send_req(8'd5);
    wait_done(2000, got, err);
    n_tests++;
    if ({got, err} !== 2'b10 || bus.cur_div_o !== 8'd5) begin
      n_fail++; $display("FAIL arst_after: got done=%b err=%b cur=%0d expected 1 0 5", got, err, bus.cur_div_o);
    end
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_div_i   = 8'd0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_back_to_back();
    test_drp_timeout();
    test_lock();
    test_async_reset();
    n_tests++;
    if (proto_err != 0) begin
      n_fail++; $display("FAIL drp_overlap: got %0d overlapping accesses expected 0", proto_err);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
